// File: rtl/riscv_pkg.sv
// riscv_pkg: instruction kinds and RV32I opcodes shared by the control
// decoder and the program loader, plus the loader FSM state type.
package riscv_pkg;

  typedef enum logic [2:0] {
    K_R      = 3'd0,
    K_IALU   = 3'd1,
    K_LOAD   = 3'd2,
    K_STORE  = 3'd3,
    K_BRANCH = 3'd4,
    K_JAL    = 3'd5,
    K_LUI    = 3'd6,
    K_JALR   = 3'd7
  } instr_kind_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } ldr_state_t;

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// instr_field_packer: combinational encoder, instruction fields -> RV32I word.
//  kind/rd/rs1/rs2/funct3/funct7b5/imm in; word out, range_ok=1 when the
//  immediate is representable for that kind (always 1 for R-type).
module instr_field_packer
  import riscv_pkg::*;
(
  input  instr_kind_t kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  // Signed fit tests: the bits above the field's sign bit must all equal it.
  logic fits12, fits13, fits21, is_shift;
  assign fits12   = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13   = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21   = (&imm[31:20]) | ~(|imm[31:20]);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    word     = '0;
    range_ok = 1'b0;
    case (kind)
      K_R: begin
        word     = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OPC_R};
        range_ok = 1'b1;
      end
      K_IALU: begin
        if (is_shift) begin
          // shamt is unsigned 0..31; instr[30] selects SRAI vs SRLI
          word     = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OPC_IALU};
          range_ok = ~(|imm[31:5]);
        end else begin
          word     = {imm[11:0], rs1, funct3, rd, OPC_IALU};
          range_ok = fits12;
        end
      end
      K_LOAD: begin
        word     = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        range_ok = fits12;
      end
      K_STORE: begin
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        range_ok = fits12;
      end
      K_BRANCH: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        range_ok = fits13 & ~imm[0];
      end
      K_JAL: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        range_ok = fits21 & ~imm[0];
      end
      K_LUI: begin
        word     = {imm[31:12], rd, OPC_LUI};
        range_ok = ~(|imm[11:0]);
      end
      K_JALR: begin
        word     = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
        range_ok = fits12;
      end
      default: begin
        word     = '0;
        range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts instruction field bundles (valid/ready),
// encodes them to RV32I and writes them sequentially to instruction memory.
//  clk, rst_n (async low), start (sync clear/abort)
//  in_valid/in_ready + in_kind/in_rd/in_rs1/in_rs2/in_funct3/in_funct7b5/in_imm
//  imem_we/imem_addr/imem_wdata out, imem_ack in (write held until ack)
//  word_count, full, imm_err (1-cycle reject pulse)
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  instr_kind_t   in_kind,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic          in_funct7b5,
  input  logic [31:0]   in_imm,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_ack,
  output logic [CW-1:0] word_count,
  output logic          full,
  output logic          imm_err
);

  ldr_state_t  state_q, state_d;
  logic [31:0] enc_word;
  logic        range_ok, accept;

  instr_field_packer u_packer (
    .kind     (in_kind),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .imm      (in_imm),
    .word     (enc_word),
    .range_ok (range_ok)
  );

  assign full     = (word_count == CW'(DEPTH));
  assign in_ready = (state_q == S_IDLE) && !full && !start;
  assign accept   = in_valid && in_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state; start overrides everything, including a same-cycle ack
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept && range_ok) state_d = S_WRITE;
        S_WRITE: if (imem_ack)           state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    imem_we = (state_q == S_WRITE);
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      word_count <= '0;
      imm_err    <= 1'b0;
    end else begin
      imm_err <= accept && !range_ok;
      if (start) begin
        imem_addr  <= BASE_ADDR;
        word_count <= '0;
      end else begin
        if (accept && range_ok) imem_wdata <= enc_word;
        if (state_q == S_WRITE && imem_ack) begin
          word_count <= word_count + 1'b1;
          // last slot: keep the address on the final word rather than run past it
          if (word_count != CW'(DEPTH - 1)) imem_addr <= imem_addr + 32'd4;
        end
      end
    end
  end

endmodule
